add_round_key_seq: RTL and testbench

Parametrised, handshaked AddRoundKey stage for the AES datapath. It captures a state/round-key pair and XORs them lane by lane over a configurable number of beats, so the same block serves a full-width single-cycle datapath and narrow area-optimised cores. The result sits in an output register until downstream accepts it. The block sits between the MixColumns (or initial input) stage and the next round's SubBytes stage.

---
 rtl/add_round_key_seq.sv | 108 ++++++++++
 tb/tb_add_round_key_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_round_key_seq.sv
// Handshaked, multi-beat AES AddRoundKey stage: XORs one LANE_W lane per cycle, MSB lane first.
// Optional feature macro ARK_BYPASS_EN adds a bypass input that passes the state through unmodified.
module add_round_key_seq #(
    parameter int STATE_W = 128,
    parameter int LANE_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    input  logic [STATE_W-1:0] round_key,
`ifdef ARK_BYPASS_EN
    input  logic               bypass,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out,
    output logic               busy
);

    localparam int BEATS = STATE_W / LANE_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] data_q, key_q;
    logic [STATE_W-1:0] result_q, result_d;
    logic               accept;
    logic               last_beat;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt_q == LAST_BEAT);

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign state_out = result_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (last_beat) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Output handshake and the next accept share this edge.
                if (out_ready) begin
                    state_d = accept ? BUSY : IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        result_d = result_q;
        if (state_q == BUSY) begin
            for (int k = 0; k < BEATS; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    result_d[STATE_W-1-k*LANE_W -: LANE_W] =
                        data_q[STATE_W-1-k*LANE_W -: LANE_W] ^
                        key_q[STATE_W-1-k*LANE_W -: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            key_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            if (accept) begin
                data_q <= state_in;
                // A bypassed block is stored with a zero key so the XOR passes the state through.
`ifdef ARK_BYPASS_EN
                key_q  <= bypass ? '0 : round_key;
`else
                key_q  <= round_key;
`endif
            end
        end
    end

endmodule

// File: tb/tb_add_round_key_seq.sv
// Self-checking bench for add_round_key_seq: vector table, random vectors against a word-level
// XOR model, plus backpressure, streaming, mid-block reset and (with ARK_BYPASS_EN) bypass sequences.
module tb_add_round_key_seq;

    localparam int W     = 128;
    localparam int LANE  = 32;
    localparam int BEATS = W / LANE;

    localparam logic [W-1:0] FIPS_S = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [W-1:0] FIPS_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [W-1:0] FIPS_E = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] k;
        logic [W-1:0] e;
        logic         b;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] state_in = '0;
    logic [W-1:0] round_key = '0;
`ifdef ARK_BYPASS_EN
    logic         bypass = 1'b0;
`endif
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [W-1:0] state_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    vec_t vecs[12];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_round_key_seq #(.STATE_W(W), .LANE_W(LANE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .round_key (round_key),
`ifdef ARK_BYPASS_EN
        .bypass    (bypass),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    function automatic logic [W-1:0] ref_ark(input logic [W-1:0] s, input logic [W-1:0] k,
                                             input logic b);
        return b ? s : (s ^ k);
    endfunction

    function automatic logic [W-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [W-1:0] blk(input int i);
        logic [7:0] b;
        b = 8'(i * 17);
        return {16{b}};
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one block, holds it until accepted, then scrambles the inputs.
    task automatic applyStimulus(input logic [W-1:0] s, input logic [W-1:0] k, input logic b);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        state_in  = s;
        round_key = k;
`ifdef ARK_BYPASS_EN
        bypass    = b;
`endif
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("accept_ready", W'(in_ready), W'(1'b1));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        state_in  = rnd128();
        round_key = rnd128();
`ifdef ARK_BYPASS_EN
        bypass    = ~b;
`endif
        checkOutput("busy_after_accept", W'(busy), W'(1'b1));
    endtask

    task automatic waitResult(input string name, input logic [W-1:0] exp);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_latency"}, W'(n), W'(BEATS));
        checkOutput(name, state_out, exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] s1, k1, e1, s2, k2, e2;
        logic         seen;
        logic         acc;
        int           idx;
        int           rise[$];

        vecs[0] = '{FIPS_S, FIPS_K, FIPS_E, 1'b0};
        vecs[1] = '{W'(0), W'(0), W'(0), 1'b0};
        vecs[2] = '{{W{1'b1}}, W'(0), {W{1'b1}}, 1'b0};
        vecs[3] = '{128'h00000000ffffffff123456789abcdef0,
                    128'hffffffff00000000876543210fedcba9,
                    128'hffffffffffffffff9551155995511559, 1'b0};
        for (int i = 4; i < 12; i++) begin
            vecs[i].s = rnd128();
            vecs[i].k = rnd128();
            vecs[i].b = 1'b0;
            vecs[i].e = ref_ark(vecs[i].s, vecs[i].k, 1'b0);
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_out_valid", W'(out_valid), W'(1'b0));
        checkOutput("reset_busy", W'(busy), W'(1'b0));
        checkOutput("reset_state_out", state_out, W'(0));
        checkOutput("reset_in_ready", W'(in_ready), W'(1'b1));

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].s, vecs[i].k, vecs[i].b);
            waitResult($sformatf("vec%0d", i), vecs[i].e);
        end
        @(posedge clk);
        #1;
        checkOutput("idle_after_table", W'({busy, out_valid}), W'(2'b00));

        // Backpressure: hold DONE for 10 cycles, pulse in_valid, then handshake and accept together.
        out_ready = 1'b0;
        s1 = rnd128(); k1 = rnd128(); e1 = ref_ark(s1, k1, 1'b0);
        s2 = rnd128(); k2 = rnd128(); e2 = ref_ark(s2, k2, 1'b0);
        applyStimulus(s1, k1, 1'b0);
        waitResult("bp_first", e1);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            checkOutput("bp_hold_data", state_out, e1);
            checkOutput("bp_hold_valid", W'(out_valid), W'(1'b1));
            checkOutput("bp_in_ready", W'(in_ready), W'(1'b0));
            in_valid  = (j == 4);
            state_in  = rnd128();
            round_key = rnd128();
        end
        @(negedge clk);
        in_valid  = 1'b1;
        state_in  = s2;
        round_key = k2;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp_handshake_valid", W'(out_valid), W'(1'b0));
        checkOutput("bp_handshake_accept", W'(busy), W'(1'b1));
        waitResult("bp_second", e2);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            seen = seen | busy | out_valid;
        end
        checkOutput("bp_no_extra_accept", W'(seen), W'(1'b0));

        // Streaming: continuous in_valid with out_ready high.
        @(negedge clk);
        idx       = 1;
        in_valid  = 1'b1;
        state_in  = blk(1);
        round_key = blk(1);
        for (int t = 0; t < 60 && rise.size() < 3; t++) begin
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (out_valid) begin
                rise.push_back(cyc);
                checkOutput("stream_data", state_out, W'(0));
            end
            if (acc) begin
                idx++;
                if (idx <= 3) begin
                    state_in  = blk(idx);
                    round_key = blk(idx);
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("stream_count", W'(rise.size()), W'(3));
        for (int i = 1; i < rise.size(); i++)
            checkOutput("stream_gap", W'(rise[i] - rise[i-1]), W'(BEATS + 1));
        repeat (2) @(posedge clk);
        #1;

        // Reset on beat 2 discards the block.
        applyStimulus(FIPS_S, FIPS_K, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midrst_out_valid", W'(out_valid), W'(1'b0));
        checkOutput("midrst_busy", W'(busy), W'(1'b0));
        checkOutput("midrst_state_out", state_out, W'(0));
        checkOutput("midrst_in_ready", W'(in_ready), W'(1'b1));
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        checkOutput("midrst_no_valid", W'(seen), W'(1'b0));
        applyStimulus(FIPS_S, FIPS_K, 1'b0);
        waitResult("midrst_recover", FIPS_E);

`ifdef ARK_BYPASS_EN
        applyStimulus(128'h00112233445566778899aabbccddeeff, rnd128(), 1'b1);
        waitResult("bypass", 128'h00112233445566778899aabbccddeeff);
        s1 = rnd128(); k1 = rnd128();
        applyStimulus(s1, k1, 1'b0);
        waitResult("bypass_off", ref_ark(s1, k1, 1'b0));
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
